// File: rtl/keypad_pkg.sv
// Shared keypad constants, legacy 4x4 legend lookup and event record type.
// The counter width bounds DEBOUNCE at 15 frames.
package keypad_pkg;

    localparam int CNT_W = 4;

    // Matrix index (row*4 + col) of each legend on the legacy 4x4 pad.
    localparam int KEY_1 = 0;
    localparam int KEY_2 = 1;
    localparam int KEY_3 = 2;
    localparam int KEY_A = 3;
    localparam int KEY_4 = 4;
    localparam int KEY_5 = 5;
    localparam int KEY_6 = 6;
    localparam int KEY_B = 7;
    localparam int KEY_7 = 8;
    localparam int KEY_8 = 9;
    localparam int KEY_9 = 10;
    localparam int KEY_C = 11;
    localparam int KEY_E = 12;
    localparam int KEY_0 = 13;
    localparam int KEY_F = 14;
    localparam int KEY_D = 15;

    typedef struct packed {
        logic [7:0] code;
        logic       is_release;
    } key_event_t;

    localparam logic [3:0] LEGEND_4X4 [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [3:0] keymap_4x4(input logic [3:0] idx);
        return LEGEND_4X4[idx];
    endfunction

endpackage

// File: rtl/keypad_key_filter.sv
// One key's debounce counter and debounced bit; the counter moves only at frame end.
// eligible_o reflects the next count so the top can present an event the following cycle.
module keypad_key_filter
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic frame_end_i,
    input  logic raw_i,
    input  logic hold_i,
    input  logic commit_i,
    output logic eligible_o,
    output logic down_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             down_q;
    logic             down_d;

    always_comb begin
        cnt_d  = cnt_q;
        down_d = down_q;
        if (commit_i) begin
            cnt_d  = '0;
            down_d = ~down_q;
        end else if (frame_end_i && !hold_i) begin
            if (raw_i == down_q) begin
                cnt_d = '0;
            end else if (cnt_q != LIMIT) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            down_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            down_q <= down_d;
        end
    end

    assign eligible_o = (cnt_d == LIMIT);
    assign down_o     = down_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row-scanned keypad with per-key debounce; events appear 1 cycle after the frame end that qualifies them.
// A presented event holds code/release stable until ev_ready_i; the key change commits only on acceptance.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter  int NROWS    = 4,
    parameter  int NCOLS    = 4,
    parameter  int SCAN_DIV = 65536,
    parameter  int DEBOUNCE = 4,
    localparam int KW       = $clog2(NROWS * NCOLS)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    output logic [NROWS-1:0]         rows_o,
    input  logic [NCOLS-1:0]         cols_i,
    output logic                     ev_valid_o,
    input  logic                     ev_ready_i,
    output logic [KW-1:0]            ev_code_o,
    output logic                     ev_release_o,
    output logic [NROWS*NCOLS-1:0]   key_down_o,
    output logic                     any_down_o
);

    localparam int NKEYS = NROWS * NCOLS;
    localparam int DW    = $clog2(SCAN_DIV);
    localparam logic [DW-1:0]    DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [NROWS-1:0] ROWS_RESET = {{(NROWS-1){1'b1}}, 1'b0};

    logic [NCOLS-1:0] sync1_q;
    logic [NCOLS-1:0] sync2_q;
    logic [DW-1:0]    dwell_q;
    logic [DW-1:0]    dwell_d;
    logic [NROWS-1:0] rows_q;
    logic [NROWS-1:0] rows_d;
    logic [NKEYS-1:0] raw_q;
    logic [NKEYS-1:0] raw_d;
    logic             sample;
    logic             frame_end;

    logic [NKEYS-1:0] eligible;
    logic [NKEYS-1:0] down;
    logic [NKEYS-1:0] commit;
    logic [NKEYS-1:0] hold;

    logic             ev_valid_q;
    logic             ev_valid_d;
    logic [KW-1:0]    ev_code_q;
    logic [KW-1:0]    ev_code_d;
    logic             ev_release_q;
    logic             ev_release_d;
    logic             any_down_q;
    logic             any_down_d;
    logic             accept;
    logic             found;
    logic [KW-1:0]    pick;

    assign sample    = (dwell_q == DWELL_LAST);
    assign frame_end = sample && !rows_q[NROWS-1];
    assign accept    = ev_valid_q && ev_ready_i;

    // raw_d already carries the row being sampled, so at frame end the filters see the full frame.
    always_comb begin
        dwell_d = sample ? '0 : dwell_q + DW'(1);
        rows_d  = sample ? {rows_q[NROWS-2:0], rows_q[NROWS-1]} : rows_q;
        raw_d   = raw_q;
        for (int r = 0; r < NROWS; r++) begin
            for (int c = 0; c < NCOLS; c++) begin
                if (sample && !rows_q[r]) begin
                    raw_d[r*NCOLS + c] = ~sync2_q[c];
                end
            end
        end
    end

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        assign commit[i] = accept && (ev_code_q == KW'(i));
        assign hold[i]   = ev_valid_q && !ev_ready_i && (ev_code_q == KW'(i));

        keypad_key_filter #(
            .DEBOUNCE (DEBOUNCE)
        ) u_filter (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .frame_end_i (frame_end),
            .raw_i       (raw_d[i]),
            .hold_i      (hold[i]),
            .commit_i    (commit[i]),
            .eligible_o  (eligible[i]),
            .down_o      (down[i])
        );
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                found = 1'b1;
                pick  = KW'(i);
            end
        end
    end

    // The accepted key's counter clears in the same cycle, so it never wins the reload.
    always_comb begin
        ev_valid_d   = ev_valid_q;
        ev_code_d    = ev_code_q;
        ev_release_d = ev_release_q;
        if (!ev_valid_q || accept) begin
            ev_valid_d = found;
            if (found) begin
                ev_code_d    = pick;
                ev_release_d = down[pick];
            end
        end
        any_down_d = |(down ^ commit);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            dwell_q      <= '0;
            rows_q       <= ROWS_RESET;
            raw_q        <= '0;
            ev_valid_q   <= 1'b0;
            ev_code_q    <= '0;
            ev_release_q <= 1'b0;
            any_down_q   <= 1'b0;
        end else begin
            sync1_q      <= cols_i;
            sync2_q      <= sync1_q;
            dwell_q      <= dwell_d;
            rows_q       <= rows_d;
            raw_q        <= raw_d;
            ev_valid_q   <= ev_valid_d;
            ev_code_q    <= ev_code_d;
            ev_release_q <= ev_release_d;
            any_down_q   <= any_down_d;
        end
    end

    assign rows_o       = rows_q;
    assign ev_valid_o   = ev_valid_q;
    assign ev_code_o    = ev_code_q;
    assign ev_release_o = ev_release_q;
    assign key_down_o   = down;
    assign any_down_o   = any_down_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench: a physical key matrix drives the scanner; a frame-level behavioural model predicts every output.
module tb_keypad_matrix_scanner;
    import keypad_pkg::*;

    localparam int NR = 4;
    localparam int NC = 4;
    localparam int SD = 8;
    localparam int DB = 3;
    localparam int NK = NR * NC;
    localparam int FR = NR * SD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [NR-1:0] rows;
    logic [NC-1:0] cols;
    logic          ev_valid;
    logic          ev_ready;
    logic [3:0]    ev_code;
    logic          ev_release;
    logic [NK-1:0] key_down;
    logic          any_down;
    logic [NK-1:0] phys;

    logic [1:0]    rows2;
    logic [2:0]    cols2;
    logic          valid2;
    logic          ready2;
    logic [2:0]    code2;
    logic          rel2;
    logic [5:0]    kd2;
    logic          any2;
    logic [5:0]    phys2;

    // Physical matrix: a held key pulls its column low while its row is driven low.
    always_comb begin
        cols = '1;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (!rows[r] && phys[r*NC + c]) cols[c] = 1'b0;
        cols2 = '1;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                if (!rows2[r] && phys2[r*3 + c]) cols2[c] = 1'b0;
    end

    keypad_matrix_scanner #(.NROWS(NR), .NCOLS(NC), .SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk_i(clk), .reset_i(reset), .rows_o(rows), .cols_i(cols),
        .ev_valid_o(ev_valid), .ev_ready_i(ev_ready), .ev_code_o(ev_code),
        .ev_release_o(ev_release), .key_down_o(key_down), .any_down_o(any_down)
    );

    keypad_matrix_scanner #(.NROWS(2), .NCOLS(3), .SCAN_DIV(4), .DEBOUNCE(1)) dut2 (
        .clk_i(clk), .reset_i(reset), .rows_o(rows2), .cols_i(cols2),
        .ev_valid_o(valid2), .ev_ready_i(ready2), .ev_code_o(code2),
        .ev_release_o(rel2), .key_down_o(kd2), .any_down_o(any2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Reference model state: cycles since reset, per-key counts, debounced bits, pending event.
    int            cyc = 0;
    int            n_acc = 0;
    bit            started = 1'b0;
    int            m_cnt [NK];
    bit [NK-1:0]   m_raw;
    bit [NK-1:0]   m_down;
    bit            m_valid;
    logic [3:0]    m_code;
    bit            m_rel;
    bit            acc, stall, fe;
    int            row;

    initial forever begin
        @(posedge clk);
        started = 1'b1;
        if (reset) begin
            cyc = 0;
            m_raw = '0;
            m_down = '0;
            m_valid = 1'b0;
            m_code = '0;
            m_rel = 1'b0;
            for (int i = 0; i < NK; i++) m_cnt[i] = 0;
        end else begin
            acc   = m_valid && ev_ready;
            stall = m_valid && !ev_ready;
            if (acc) n_acc++;
            if (cyc % SD == SD - 1) begin
                row = (cyc / SD) % NR;
                for (int c = 0; c < NC; c++) m_raw[row*NC + c] = phys[row*NC + c];
            end
            fe = (cyc % FR == FR - 1);
            for (int i = 0; i < NK; i++) begin
                if (acc && i == int'(m_code)) begin
                    m_cnt[i] = 0;
                    m_down[i] = !m_down[i];
                end else if (stall && i == int'(m_code)) begin
                    m_cnt[i] = m_cnt[i];
                end else if (fe) begin
                    if (m_raw[i] == m_down[i]) m_cnt[i] = 0;
                    else m_cnt[i] = (m_cnt[i] + 1 > DB) ? DB : m_cnt[i] + 1;
                end
            end
            if (!m_valid || acc) begin
                m_valid = 1'b0;
                for (int i = NK - 1; i >= 0; i--) begin
                    if (m_cnt[i] == DB) begin
                        m_valid = 1'b1;
                        m_code = 4'(i);
                        m_rel = m_down[i];
                    end
                end
            end
            cyc++;
        end
    end

    logic [NR-1:0] exp_rows;
    initial forever begin
        @(negedge clk);
        if (started) begin
            exp_rows = ~(4'b0001 << ((cyc / SD) % NR));
            check("state{rows,valid,key_down,any}",
                  32'({rows, ev_valid, key_down, any_down}),
                  32'({exp_rows, m_valid, m_down, |m_down}));
            if (m_valid)
                check("event{code,release}", 32'({ev_code, ev_release}), 32'({m_code, m_rel}));
        end
    end

    task automatic at_cyc(input int n);
        for (int k = 0; k < 20000 && cyc != n; k++) @(negedge clk);
        check("reach_cycle", 32'(cyc), 32'(n));
    endtask

    int nv, unst, n0;

    initial begin
        reset = 1'b1; ev_ready = 1'b1; phys = '0; ready2 = 1'b1; phys2 = '0;
        repeat (3) @(negedge clk);
        check("rst_rows", 32'(rows), 32'b1110);
        check("rst_valid", 32'(ev_valid), 0);
        check("rst_code", 32'(ev_code), 0);
        check("rst_release", 32'(ev_release), 0);
        check("rst_key_down", 32'(key_down), 0);
        check("rst_any_down", 32'(any_down), 0);
        check("keymap_13", 32'(keymap_4x4(4'd13)), 'h0);
        check("keymap_3", 32'(keymap_4x4(4'd3)), 'hA);
        reset = 1'b0;

        at_cyc(1);  phys2[5] = 1'b1;
        at_cyc(2);  phys[6] = 1'b1;
        at_cyc(7);  check("sweep_early", 32'(valid2), 0);
        at_cyc(8);
        check("sweep_valid", 32'(valid2), 1);
        check("sweep_code", 32'(code2), 5);
        check("sweep_release", 32'(rel2), 0);
        check("rows_8", 32'(rows), 32'b1101);
        at_cyc(9);
        check("sweep_key_down", 32'(kd2), 32'b100000);
        check("sweep_any", 32'(any2), 1);
        at_cyc(16); check("rows_16", 32'(rows), 32'b1011);
        at_cyc(24); check("rows_24", 32'(rows), 32'b0111);
        at_cyc(32); check("rows_32", 32'(rows), 32'b1110);

        at_cyc(95); check("press_early", 32'(ev_valid), 0);
        at_cyc(96);
        check("press_valid", 32'(ev_valid), 1);
        check("press_code", 32'(ev_code), 6);
        check("press_release", 32'(ev_release), 0);
        at_cyc(97);
        check("press_key_down", 32'(key_down), 'h0040);
        check("press_any", 32'(any_down), 1);
        check("press_drop", 32'(ev_valid), 0);
        at_cyc(98); phys[6] = 1'b0;
        at_cyc(191); check("rel_early", 32'(ev_valid), 0);
        at_cyc(192);
        check("rel_valid", 32'(ev_valid), 1);
        check("rel_code", 32'(ev_code), 6);
        check("rel_release", 32'(ev_release), 1);
        at_cyc(193);
        check("rel_key_down", 32'(key_down), 0);
        check("rel_any", 32'(any_down), 0);

        at_cyc(194); phys[6] = 1'b1;
        nv = 0;
        repeat (64) begin @(negedge clk); if (ev_valid) nv++; end
        phys[6] = 1'b0;
        repeat (42) begin @(negedge clk); if (ev_valid) nv++; end
        check("glitch_no_event", 32'(nv), 0);

        at_cyc(322); ev_ready = 1'b0; phys[0] = 1'b1; phys[15] = 1'b1;
        at_cyc(415); check("dual_early", 32'(ev_valid), 0);
        at_cyc(416);
        check("dual_valid", 32'(ev_valid), 1);
        check("dual_code", 32'(ev_code), 0);
        unst = 0;
        repeat (100) begin @(negedge clk); if (!ev_valid || ev_code != 4'd0 || ev_release) unst++; end
        check("stall_stable", 32'(unst), 0);
        ev_ready = 1'b1;
        at_cyc(517);
        check("second_valid", 32'(ev_valid), 1);
        check("second_code", 32'(ev_code), 15);
        check("first_committed", 32'(key_down), 'h0001);
        at_cyc(518);
        check("both_down", 32'(key_down), 'h8001);
        check("both_drop", 32'(ev_valid), 0);

        at_cyc(530); phys = '0; ev_ready = 1'b0;
        at_cyc(645);
        check("pre_reset_valid", 32'(ev_valid), 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_rows", 32'(rows), 32'b1110);
        check("mid_rst_valid", 32'(ev_valid), 0);
        check("mid_rst_code", 32'(ev_code), 0);
        check("mid_rst_release", 32'(ev_release), 0);
        check("mid_rst_key_down", 32'(key_down), 0);
        check("mid_rst_any", 32'(any_down), 0);
        reset = 1'b0; ev_ready = 1'b1;

        n0 = n_acc;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            reset = (k == 2000);
            ev_ready = (k % 500 < 120) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (cyc % SD >= 1 && cyc % SD <= 3 && $urandom_range(0, 40) == 0)
                phys[$urandom_range(0, NK - 1)] ^= 1'b1;
        end
        check("random_events_seen", 32'(n_acc > n0 + 3), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
